// File: rtl/siga_pkg.sv
// siga_pkg: shared widths, state encoding and beat-count helpers for the SIG_NAMEA serializer
package siga_pkg;
  localparam int SIGA_W = 224;
  localparam int SIGA_HI_LSB = 128;
  localparam int SIGA_LO_MSB = 127;
  typedef enum logic {IDLE, SEND} siga_state_e;
  function automatic int nbeats(input int out_w);
    return SIGA_W / out_w;
  endfunction
  function automatic bit beat_w_ok(input int out_w);
    return out_w > 0 && out_w <= SIGA_W && (SIGA_W % out_w) == 0;
  endfunction
endpackage

// File: rtl/siga_beat_serializer.sv
// siga_beat_serializer: splits each 224-bit SIG_NAMEA word into OUT_W-bit beats, LSB first; SIGA_BEAT_PARITY_EN adds out_par
module siga_beat_serializer
  import siga_pkg::*;
#(
  parameter int FOO = 8,
  parameter int OUT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SIGA_W-1:0]  sig_namea,
  input  logic [FOO*4-2:0]   sig_nameb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_first,
  output logic               out_last,
  output logic [FOO*4-2:0]   out_tag
`ifdef SIGA_BEAT_PARITY_EN
  ,
  output logic               out_par
`endif
);
  localparam int NBEATS = nbeats(OUT_W);
  localparam int IW = NBEATS > 1 ? $clog2(NBEATS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBEATS - 1);
  localparam logic S_IDLE = 1'(IDLE);
  localparam logic S_SEND = 1'(SEND);
  if (!beat_w_ok(OUT_W)) begin : g_bad_out_w
    $error("siga_beat_serializer: OUT_W must divide 224");
  end
  logic              state;
  logic [IW-1:0]     idx;
  logic [SIGA_W-1:0] shreg;
  logic              accept;
  logic              beat;
  logic              on_last;
  assign on_last   = idx == LAST;
  assign out_valid = state == S_SEND;
  assign in_ready  = state == S_IDLE || (on_last && out_ready);
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign out_data  = shreg[OUT_W-1:0];
  assign out_first = out_valid && idx == '0;
  assign out_last  = out_valid && on_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      shreg   <= '0;
      out_tag <= '0;
    end else if (accept) begin
      state   <= S_SEND;
      idx     <= '0;
      shreg   <= sig_namea;
      out_tag <= sig_nameb;
    end else if (beat) begin
      state <= on_last ? S_IDLE : S_SEND;
      idx   <= on_last ? '0 : idx + IW'(1);
      shreg <= shreg >> OUT_W;
    end
  end
`ifdef SIGA_BEAT_PARITY_EN
  logic word_par;
  logic par_acc;
  assign out_par = ^out_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      word_par <= 1'b0;
      par_acc  <= 1'b0;
    end else if (accept) begin
      word_par <= ^sig_namea;
      par_acc  <= 1'b0;
    end else if (beat) begin
      par_acc <= par_acc ^ out_par;
    end
  end
  // beat parities folded over the whole word must reproduce the captured word's parity
  always_ff @(posedge clk) begin
    if (!rst && beat && on_last)
      assert ((par_acc ^ out_par) == word_par) else $error("siga_beat_serializer: parity fold mismatch");
  end
`endif
endmodule

// File: tb/tb_siga_beat_serializer.sv
// tb_siga_beat_serializer: random and directed stimulus checked against a beat-queue reference model
module tb_siga_beat_serializer;
  localparam int FOO = 8;
  localparam int OUT_W = 32;
  localparam int TW = FOO * 4 - 1;
  localparam int NB = 224 / OUT_W;
  typedef struct {
    logic [OUT_W-1:0] d;
    logic             f;
    logic             l;
    logic [TW-1:0]    t;
  } beat_t;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [223:0]      sig_namea = '0;
  logic [TW-1:0]     sig_nameb = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic              out_first;
  logic              out_last;
  logic [TW-1:0]     out_tag;
`ifdef SIGA_BEAT_PARITY_EN
  logic              out_par;
`endif
  int n_tests = 0;
  int n_fail = 0;
  int accepts = 0;
  beat_t q[$];
  siga_beat_serializer #(.FOO(FOO), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sig_namea(sig_namea), .sig_nameb(sig_nameb), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_first(out_first),
    .out_last(out_last), .out_tag(out_tag)
`ifdef SIGA_BEAT_PARITY_EN
    , .out_par(out_par)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic iv, input logic [223:0] w, input logic [TW-1:0] tg, input logic ordy, input logic r);
    logic exp_rdy;
    beat_t b;
    @(negedge clk);
    rst = r;
    in_valid = iv;
    sig_namea = w;
    sig_nameb = tg;
    out_ready = ordy;
    #1;
    exp_rdy = q.size() == 0 || (q.size() == 1 && ordy);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].d);
      check("out_first", out_first, q[0].f);
      check("out_last", out_last, q[0].l);
      check("out_tag", out_tag, q[0].t);
`ifdef SIGA_BEAT_PARITY_EN
      check("out_par", out_par, ^q[0].d);
`endif
    end else begin
      check("out_first_idle", out_first, 1'b0);
      check("out_last_idle", out_last, 1'b0);
    end
    if (r) q.delete();
    else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (iv && exp_rdy) begin
        accepts++;
        for (int i = 0; i < NB; i++) begin
          b.d = OUT_W'(w >> (i * OUT_W));
          b.f = i == 0;
          b.l = i == NB - 1;
          b.t = tg;
          q.push_back(b);
        end
      end
    end
  endtask
  function automatic logic [223:0] rand_word();
    logic [223:0] w;
    for (int i = 0; i < 7; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction
  initial begin
    logic [223:0] w0, w1, w2;
    w0 = '0;
    for (int i = 0; i < NB; i++) w0[i*OUT_W +: OUT_W] = OUT_W'(i);
    w1 = rand_word();
    w2 = rand_word();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, '0);
    check("rst_out_tag", out_tag, '0);
    check("rst_out_first", out_first, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    cycle(1'b1, w0, TW'(31'h1234), 1'b1, 1'b0);
    repeat (NB + 1) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    accepts = 0;
    for (int c = 0; c < 2 * NB + 3; c++)
      cycle(accepts < 2, accepts == 0 ? w1 : w2, accepts == 0 ? TW'(7) : TW'(9), 1'b1, 1'b0);
    cycle(1'b1, w0, TW'(55), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (NB) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, w0, TW'(66), 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, w1, TW'(77), 1'b1, 1'b0);
    repeat (NB) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, w0, TW'(88), 1'b1, 1'b0);
    repeat (4) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, w1, TW'(99), 1'b1, 1'b1);
    cycle(1'b1, w2, TW'(100), 1'b1, 1'b0);
    repeat (NB + 1) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 600; c++)
      cycle($urandom_range(0, 1) == 1, rand_word(), TW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
